// File: rtl/pyjamask96_pkg.sv
// Shared definitions for the Pyjamask-96 streaming wrapper: FSM encoding,
// block geometry and byte-lane helpers.
package pyjamask96_pkg;

  localparam int NB_DATA_BYTES    = 12;
  localparam int NB_KEY_BYTES     = 16;
  localparam int WATCHDOG_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Plaintext byte idx, byte 0 in the top lane; indices past the block read as zero padding.
  function automatic logic [7:0] data_byte(input logic [95:0] d, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx < 4'(NB_DATA_BYTES)) b = d[8*(NB_DATA_BYTES-1-int'(idx)) +: 8];
    return b;
  endfunction

  // Key byte idx, byte 0 in the top lane.
  function automatic logic [7:0] key_byte(input logic [127:0] k, input logic [3:0] idx);
    return k[8*(NB_KEY_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/pyjamask96_stream_if.sv
// Valid/ready streaming wrapper around a byte-serial Pyjamask-96 core:
// captures one block, serialises key and plaintext into the core, collects
// twelve ciphertext bytes and holds the result until downstream takes it.
module pyjamask96_stream_if
  import pyjamask96_pkg::*;
#(
  parameter int WATCHDOG = WATCHDOG_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [95:0]  in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [95:0]  out_data,
  output logic         err,
  output logic         core_load,
  output logic         core_start,
  output logic [7:0]   core_byte_in,
  output logic [7:0]   core_key_byte,
  input  logic         core_valid,
  input  logic [7:0]   core_byte_out
);

  localparam int WD_W = $clog2(WATCHDOG) + 1;

  state_t           state_q, state_d;
  logic [95:0]      data_q;
  logic [127:0]     key_q;
  logic [3:0]       idx_q;
  logic [3:0]       rx_cnt_q;
  logic [WD_W-1:0]  wd_cnt_q;
  logic             got_first_q;
  logic [95:0]      out_data_q;

  logic             accept;
  logic             last_byte;
  logic             wd_expire;
  logic [3:0]       lane_idx;

  assign accept    = in_valid && in_ready;
  assign last_byte = (state_q == ST_WAIT) && core_valid &&
                     (rx_cnt_q == 4'(NB_DATA_BYTES-1));
  // Watchdog only runs until the first ciphertext byte shows up.
  assign wd_expire = (state_q == ST_WAIT) && !got_first_q && !core_valid &&
                     (wd_cnt_q == WD_W'(WATCHDOG-1));
  assign lane_idx  = (state_q == ST_LOAD) ? 4'd0 : idx_q;
  assign out_data  = out_data_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_FEED;
      ST_FEED:  if (idx_q == 4'(NB_KEY_BYTES-1)) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (last_byte)      state_d = ST_HOLD;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; byte lanes are driven only while loading or feeding.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    in_ready      = (state_q == ST_IDLE) && reset_n;
    out_valid     = (state_q == ST_HOLD);
    err           = wd_expire;
    core_load     = (state_q == ST_LOAD);
    core_start    = (state_q == ST_START);
    core_byte_in  = 8'h00;
    core_key_byte = 8'h00;
    if (state_q == ST_LOAD || state_q == ST_FEED) begin
      core_byte_in  = data_byte(data_q, lane_idx);
      core_key_byte = key_byte(key_q, lane_idx);
    end
  end

  // Datapath: block capture, feed index, receive counter, watchdog, result assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the captured block and result registers are reset too, so out_data reads 0 in reset.
      data_q      <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      rx_cnt_q    <= '0;
      wd_cnt_q    <= '0;
      got_first_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        data_q <= in_data;
        key_q  <= in_key;
      end
      unique case (state_q)
        ST_LOAD: idx_q <= 4'd1;
        ST_FEED: idx_q <= idx_q + 4'd1;
        ST_START: begin
          wd_cnt_q    <= '0;
          rx_cnt_q    <= '0;
          got_first_q <= 1'b0;
        end
        ST_WAIT: begin
          if (core_valid) begin
            out_data_q[8*int'(rx_cnt_q) +: 8] <= core_byte_out;
            rx_cnt_q    <= last_byte ? 4'd0 : rx_cnt_q + 4'd1;
            got_first_q <= 1'b1;
          end else if (!got_first_q) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pyjamask96_stream_if.sv
// Directed bench for pyjamask96_stream_if: feed ordering, result assembly,
// HOLD backpressure, watchdog expiry and its boundary, reset mid-feed.
module tb_pyjamask96_stream_if;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic         err;
  logic         core_load;
  logic         core_start;
  logic [7:0]   core_byte_in;
  logic [7:0]   core_key_byte;
  logic         core_valid;
  logic [7:0]   core_byte_out;

  int n_checks = 0;
  int n_bad    = 0;

  localparam logic [95:0]  D1 = 96'h00112233_44556677_8899AABB;
  localparam logic [127:0] K1 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [95:0]  D2 = 96'hFEDCBA98_76543210_0F1E2D3C;
  localparam logic [127:0] K2 = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

  pyjamask96_stream_if #(.WATCHDOG(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_key        (in_key),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .err           (err),
    .core_load     (core_load),
    .core_start    (core_start),
    .core_byte_in  (core_byte_in),
    .core_key_byte (core_key_byte),
    .core_valid    (core_valid),
    .core_byte_out (core_byte_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Handshake one block and check LOAD/FEED/START lanes. Stops early after FEED index stop_at.
  task automatic send_block(input logic [95:0] d, input logic [127:0] k, input int stop_at);
    logic [7:0] exp_d, exp_k;
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    check("hs_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    in_key   = '0;
    check("load_strobe", core_load, 1);
    check("load_start_low", core_start, 0);
    check("load_byte0", core_byte_in, d[95:88]);
    check("load_key0", core_key_byte, k[127:120]);
    check("load_in_ready", in_ready, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_d = (i <= 11) ? d[95-8*i -: 8] : 8'h00;
      exp_k = k[127-8*i -: 8];
      check($sformatf("feed_byte%0d", i), core_byte_in, exp_d);
      check($sformatf("feed_key%0d", i), core_key_byte, exp_k);
      check($sformatf("feed_strobes%0d", i), {core_load, core_start}, 2'b00);
      if (i == stop_at) return;
    end
    tick();
    check("start_strobe", core_start, 1);
    check("start_load_low", core_load, 0);
    check("start_lanes_zero", {core_byte_in, core_key_byte}, 16'h0000);
  endtask

  initial begin
    int   n;
    logic ov_seen;
    logic err_seen;

    reset_n = 1'b0;  in_valid = 1'b0; in_data = '0; in_key = '0;
    out_ready = 1'b0; core_valid = 1'b0; core_byte_out = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_outputs", {out_valid, err, core_load, core_start}, 4'b0000);
    check("rst_lanes", {core_byte_in, core_key_byte}, 16'h0000);
    check("rst_out_data", out_data, 96'h0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // core_valid in IDLE and throughout FEED must be ignored
    core_valid = 1'b1; core_byte_out = 8'hFF;
    tick();
    tick();
    check("idle_core_valid_ignored", out_data, 96'h0);
    send_block(D1, K1, 16);
    check("feed_core_valid_ignored", out_data, 96'h0);
    core_valid = 1'b0; core_byte_out = 8'h00;

    // Core returns A0..AB with one idle gap; first byte must land in [7:0]
    tick();
    for (int i = 0; i < 12; i++) begin
      core_valid = 1'b1; core_byte_out = 8'hA0 + 8'(i);
      tick();
      if (i == 10) check("no_early_out_valid", out_valid, 0);
      if (i == 5) begin
        core_valid = 1'b0;
        tick();
      end
    end
    core_valid = 1'b0;
    check("hold_out_valid", out_valid, 1);
    check("hold_out_data", out_data, 96'hABAAA9A8_A7A6A5A4_A3A2A1A0);

    // Backpressure: ten cycles with out_ready low
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_valid%0d", i), out_valid, 1);
      check($sformatf("bp_data%0d", i), out_data, 96'hABAAA9A8_A7A6A5A4_A3A2A1A0);
      check($sformatf("bp_in_ready%0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("xfer_in_ready", in_ready, 1);
    check("xfer_out_valid", out_valid, 0);

    // Watchdog: no core_valid after start
    send_block(D1, K1, 16);
    ov_seen = 1'b0;
    n = 201;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (out_valid) ov_seen = 1'b1;
      if (err) begin
        n = c;
        break;
      end
    end
    check("wd_latency", n, 64);
    check("wd_in_ready_during_err", in_ready, 0);
    tick();
    check("wd_err_width", err, 0);
    check("wd_in_ready_after", in_ready, 1);
    check("wd_no_out_valid", {ov_seen, out_valid}, 2'b00);

    // Reset asserted mid-FEED at index 7
    send_block(D2, K2, 7);
    check("feed7_byte_const", core_byte_in, 8'h10);
    check("feed7_key_const", core_key_byte, 8'h87);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_outputs", {out_valid, err, core_load, core_start}, 4'b0000);
    check("midrst_lanes", {core_byte_in, core_key_byte}, 16'h0000);
    check("midrst_out_data", out_data, 96'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    @(negedge clk);

    // Recovery block; first byte arrives in WAIT cycle 64 (watchdog boundary)
    send_block(D2, K2, 16);
    err_seen = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      tick();
      if (err) err_seen = 1'b1;
    end
    tick();
    core_valid = 1'b1; core_byte_out = 8'h50;
    #1;
    check("wd_boundary_no_err", {err_seen, err}, 2'b00);
    tick();
    core_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (err || out_valid) err_seen = 1'b1;
    end
    check("wd_disabled_after_first", err_seen, 0);
    for (int i = 1; i < 12; i++) begin
      core_valid = 1'b1; core_byte_out = 8'h50 + 8'(i);
      tick();
    end
    core_valid = 1'b0;
    check("rec_out_valid", out_valid, 1);
    check("rec_out_data", out_data, 96'h5B5A5958_57565554_53525150);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rec_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pyjamask96_stream_if.md
PYJAMASK96_STREAM_IF -- requirements
Module: pyjamask96_stream_if

Interface
REQ-001 SHALL have parameter WATCHDOG, default 64, the cycle limit from core_start to the first core_valid.
REQ-002 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  the reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream block offered.
REQ-005 SHALL have port in_ready  output  1  the block is accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data  input  96  the plaintext block; byte 0 = in_data[95:88].
REQ-007 SHALL have port in_key  input  128  the key; byte 0 = in_key[127:120].
REQ-008 SHALL have port out_valid  output  1  the ciphertext is available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_data  output  96  the ciphertext; first received byte lands in [7:0].
REQ-011 SHALL have port err  output  1  one-cycle pulse on watchdog expiry.
REQ-012 SHALL have port core_load  output  1  the load strobe to the cipher core.
REQ-013 SHALL have port core_start  output  1  the start strobe to the cipher core.
REQ-014 SHALL have port core_byte_in  output  8  the plaintext byte stream to the core.
REQ-015 SHALL have port core_key_byte  output  8  the key byte stream to the core.
REQ-016 SHALL have port core_valid  input  1  the core output byte is valid.
REQ-017 SHALL have port core_byte_out  input  8  the core output byte.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, FEED, START, WAIT, HOLD.
REQ-019 in_ready SHALL be 1 only in IDLE; on handshake at cycle T, in_data and in_key SHALL be registered and the FSM SHALL go to LOAD.
REQ-020 LOAD (T+1) SHALL assert core_load=1 for exactly one cycle, presenting data byte 0 and key byte 0.
REQ-021 FEED (T+2..T+16) SHALL present byte index 1..15 on successive cycles from a 4-bit counter: core_key_byte = key byte idx; core_byte_in = data byte idx for idx<=11 and 8'h00 for idx 12..15.
REQ-022 START (T+17) SHALL assert core_start=1 for exactly one cycle, then go to WAIT with the watchdog counter cleared.
REQ-023 In WAIT, each cycle with core_valid=1 SHALL write core_byte_out to out_data byte position n (n = 0..11 from a receive counter, bits [8n+7:8n]).
REQ-024 The 12th captured byte SHALL move the FSM to HOLD with out_valid=1 on the next cycle.
REQ-025 out_valid and out_data SHALL stay stable in HOLD until out_ready=1; that cycle completes the transfer and returns to IDLE (in_ready=1 the following cycle).
REQ-026 If WAIT lasts WATCHDOG cycles with no core_valid, err SHALL pulse for one cycle, the FSM SHALL return to IDLE, and out_valid SHALL stay 0.
REQ-027 Once the first byte has arrived, the watchdog SHALL be disabled for the remainder of the block.
REQ-028 core_valid outside WAIT SHALL be ignored.
REQ-029 core_load and core_start SHALL never be high in the same cycle.
REQ-030 core_byte_in and core_key_byte SHALL be 8'h00 outside LOAD/FEED.
REQ-031 in_valid dropping before handshake SHALL have no effect; at most one block SHALL be in flight.

Reset
REQ-032 Assertion of reset_n=0 at any time, including mid-FEED or mid-WAIT, SHALL force IDLE, clear all counters, and drive in_ready=0 during reset.
REQ-033 During reset, out_valid, err, core_load, core_start, core_byte_in, core_key_byte, and out_data SHALL all be 0.
REQ-034 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Structure
REQ-035 The shared package pyjamask96_pkg SHALL hold the FSM state encoding, the constants NB_DATA_BYTES=12, NB_KEY_BYTES=16, and WATCHDOG_DEFAULT=64.
REQ-036 The block SHALL be a single flat module with no sub-module; the cipher core is instantiated alongside it by the integrator.

Verification
REQ-037 Scenario: in_data=96'h00112233_44556677_8899AABB, in_key=128'h000102..0F at T -> core_load at T+1 with byte_in 8'h00/key 8'h00; T+16 byte_in 8'h00/key 8'h0F; core_start at T+17.
REQ-038 Scenario: core model returns bytes 8'hA0..8'hAB -> out_data=96'hABAAA9A8_A7A6A5A4_A3A2A1A0 and out_valid on the cycle after 8'hAB.
REQ-039 Scenario: out_ready held 0 for 10 cycles in HOLD -> out_valid and out_data stable; in_ready=0 throughout.
REQ-040 Scenario: no core_valid for 64 cycles after start -> err pulse of width 1, then in_ready=1, and out_valid never asserted.
REQ-041 Scenario: reset_n pulsed low at FEED index 7 -> all outputs 0 immediately; after release, a new block processes correctly.
REQ-042 Scenario: core_valid=1 while in IDLE or FEED -> out_data is unchanged and the receive counter stays 0.
